// File: rtl/font_rom_arbiter.sv
// ============================================================================
// Module      : font_rom_arbiter
// Description : Round-robin sharing of one synchronous font ROM between layers,
//               with a tag pipeline that routes each row word back to its owner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module font_rom_arbiter #(
    parameter int N_REQ   = 4,
    parameter int AW      = 5,
    parameter int DW      = 16,
    parameter int ROM_LAT = 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_flush,
    input  logic [N_REQ-1:0]   i_req,
    input  logic [N_REQ*AW-1:0] i_addr,
    output logic [N_REQ-1:0]   o_gnt,
    output logic               o_rom_rd,
    output logic [AW-1:0]      o_rom_addr,
    input  logic [DW-1:0]      i_rom_data,
    output logic [N_REQ-1:0]   o_rsp_valid,
    output logic [DW-1:0]      o_rsp_data,
    output logic               o_busy
);

    localparam int               c_IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [c_IW-1:0]  c_LAST = c_IW'(N_REQ - 1);
    localparam logic [N_REQ-1:0] c_ONE  = {{(N_REQ-1){1'b0}}, 1'b1};

    logic [c_IW-1:0]    r_ptr;
    logic [c_IW-1:0]    r_gnt_idx;
    logic [ROM_LAT-1:0] r_tag_vld;
    logic [c_IW-1:0]    r_tag_idx [ROM_LAT];

    logic [N_REQ-1:0]   w_elig;
    logic [c_IW-1:0]    w_cand;
    logic [c_IW-1:0]    w_win;
    logic               w_found;

    // A layer whose grant is currently visible sits out this arbitration round.
    always_comb begin
        w_elig  = i_req & ~o_gnt;
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = r_ptr;
        for (int i = 0; i < N_REQ; i++) begin
            w_cand = (w_cand == c_LAST) ? '0 : w_cand + 1'b1;
            if (!w_found && w_elig[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_gnt       <= '0;
            o_rom_rd    <= 1'b0;
            o_rom_addr  <= '0;
            o_rsp_valid <= '0;
            o_rsp_data  <= '0;
            r_gnt_idx   <= '0;
            r_ptr       <= c_LAST;
            r_tag_vld   <= '0;
            for (int j = 0; j < ROM_LAT; j++) begin
                r_tag_idx[j] <= '0;
            end
        end else begin
            o_gnt    <= '0;
            o_rom_rd <= 1'b0;

            // The visible grant forms stage zero; the last stage lines up with ROM data.
            for (int j = 1; j < ROM_LAT; j++) begin
                r_tag_vld[j] <= r_tag_vld[j-1];
                r_tag_idx[j] <= r_tag_idx[j-1];
            end
            r_tag_vld[0] <= o_rom_rd;
            r_tag_idx[0] <= r_gnt_idx;

            if (r_tag_vld[ROM_LAT-1]) begin
                o_rsp_valid <= c_ONE << r_tag_idx[ROM_LAT-1];
                o_rsp_data  <= i_rom_data;
            end else begin
                o_rsp_valid <= '0;
            end

            if (i_flush) begin
                r_tag_vld   <= '0;
                o_rsp_valid <= '0;
                r_ptr       <= c_LAST;
            end else if (w_found) begin
                o_gnt      <= c_ONE << w_win;
                o_rom_rd   <= 1'b1;
                o_rom_addr <= i_addr[w_win*AW +: AW];
                r_gnt_idx  <= w_win;
                r_ptr      <= w_win;
            end
        end
    end

    assign o_busy = (|r_tag_vld) | (|o_rsp_valid);

endmodule

`default_nettype wire

// File: tb/tb_font_rom_arbiter.sv
// ============================================================================
// Module      : tb_font_rom_arbiter
// Description : Directed bench for font_rom_arbiter at ROM_LAT=1 and ROM_LAT=3.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_font_rom_arbiter;

    localparam int N  = 4;
    localparam int AW = 5;
    localparam int DW = 16;

    typedef struct {
        int            k;
        logic [DW-1:0] d;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests_run = 0;
    int fails     = 0;

    exp_t q1[$];
    exp_t q3[$];
    exp_t e1, e3;

    // DUT with ROM_LAT=1
    logic            rst_n, flush, rom_rd, busy;
    logic [N-1:0]    req, gnt, rsp_valid;
    logic [N*AW-1:0] addr;
    logic [AW-1:0]   rom_addr;
    logic [DW-1:0]   rom_data, rsp_data, rom1_q;

    // DUT with ROM_LAT=3
    logic            rst3_n, flush3, rom_rd3, busy3;
    logic [N-1:0]    req3, gnt3, rsp_valid3;
    logic [N*AW-1:0] addr3;
    logic [AW-1:0]   rom_addr3;
    logic [DW-1:0]   rom_data3, rsp_data3, r3a, r3b, r3c;

    font_rom_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .ROM_LAT(1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_req(req), .i_addr(addr),
        .o_gnt(gnt), .o_rom_rd(rom_rd), .o_rom_addr(rom_addr), .i_rom_data(rom_data),
        .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data), .o_busy(busy)
    );

    font_rom_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .ROM_LAT(3)) dut3 (
        .i_clk(clk), .i_rst_n(rst3_n), .i_flush(flush3), .i_req(req3), .i_addr(addr3),
        .o_gnt(gnt3), .o_rom_rd(rom_rd3), .o_rom_addr(rom_addr3), .i_rom_data(rom_data3),
        .o_rsp_valid(rsp_valid3), .o_rsp_data(rsp_data3), .o_busy(busy3)
    );

    function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
        return {3'b101, a, ~a, 3'b010};
    endfunction

    // ROM models; poison value when no read was issued
    always @(posedge clk) begin
        rom1_q <= rom_rd ? rom_f(rom_addr) : 16'hDEAD;
        r3a    <= rom_rd3 ? rom_f(rom_addr3) : 16'hDEAD;
        r3b    <= r3a;
        r3c    <= r3b;
    end
    assign rom_data  = rom1_q;
    assign rom_data3 = r3c;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(input int k);
        logic [AW-1:0] a;
        a = addr[k*AW +: AW];
        chk("gnt", 32'(gnt), 32'(1) << k);
        chk("rom_rd", 32'(rom_rd), 1);
        chk("rom_addr", 32'(rom_addr), 32'(a));
        q1.push_back('{k, rom_f(a), cyc + 2});
    endtask

    task automatic expect_grant3(input int k);
        logic [AW-1:0] a;
        a = addr3[k*AW +: AW];
        chk("gnt3", 32'(gnt3), 32'(1) << k);
        chk("rom_addr3", 32'(rom_addr3), 32'(a));
        q3.push_back('{k, rom_f(a), cyc + 4});
    endtask

    // Response scoreboards
    always @(negedge clk) begin
        if (|rsp_valid) begin
            if (q1.size() == 0) begin
                chk("rsp_unexpected", 32'(rsp_valid), 0);
            end else begin
                e1 = q1.pop_front();
                chk("rsp_valid", 32'(rsp_valid), 32'(1) << e1.k);
                chk("rsp_data", 32'(rsp_data), 32'(e1.d));
                chk("rsp_cycle", cyc, e1.cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (|rsp_valid3) begin
            if (q3.size() == 0) begin
                chk("rsp3_unexpected", 32'(rsp_valid3), 0);
            end else begin
                e3 = q3.pop_front();
                chk("rsp3_valid", 32'(rsp_valid3), 32'(1) << e3.k);
                chk("rsp3_data", 32'(rsp_data3), 32'(e3.d));
                chk("rsp3_cycle", cyc, e3.cyc);
            end
        end
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; req = '0; addr = '0;
        rst3_n = 1'b0; flush3 = 1'b0; req3 = '0; addr3 = '0;
        tick();
        tick();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_rom_rd", 32'(rom_rd), 0);
        chk("rst_rom_addr", 32'(rom_addr), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst3_gnt", 32'(gnt3), 0);
        chk("rst3_busy", 32'(busy3), 0);
        rst_n = 1'b1; rst3_n = 1'b1;
        tick();

        // Single request from layer 2
        addr[2*AW +: AW] = 5'h13;
        req = 4'b0100;
        tick();
        expect_grant(2);
        req = '0;
        tick();
        chk("idle_gnt", 32'(gnt), 0);
        chk("idle_rom_rd", 32'(rom_rd), 0);
        chk("addr_hold", 32'(rom_addr), 32'h13);
        chk("busy_inflight", 32'(busy), 1);
        tick(); tick(); tick();

        // All layers requesting from a fresh pointer
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < N; k++) addr[k*AW +: AW] = 5'(k * 7 + 1);
        req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            tick();
            expect_grant(i % N);
        end
        req = '0;
        tick();
        chk("rr_stop", 32'(gnt), 0);
        tick(); tick();

        // Pointer wrap: grant 3, then 0, then 3
        req = 4'b1000;
        tick();
        expect_grant(3);
        req = 4'b1001;
        tick();
        expect_grant(0);
        tick();
        expect_grant(3);
        req = '0;
        tick(); tick(); tick();

        // Single layer holding its request
        req = 4'b0010;
        tick();
        expect_grant(1);
        tick();
        chk("hold_gap1", 32'(gnt), 0);
        tick();
        expect_grant(1);
        tick();
        chk("hold_gap2", 32'(gnt), 0);
        tick();
        expect_grant(1);
        req = '0;
        tick(); tick(); tick();

        // Flush with two reads in flight
        req = 4'b1111;
        tick();
        chk("fl_gnt_a", 32'(gnt), 32'b0100);
        tick();
        chk("fl_gnt_b", 32'(gnt), 32'b1000);
        chk("fl_busy_pre", 32'(busy), 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_no_gnt", 32'(gnt), 0);
        chk("fl_no_rd", 32'(rom_rd), 0);
        chk("fl_busy", 32'(busy), 0);
        chk("fl_rsp", 32'(rsp_valid), 0);
        tick();
        expect_grant(0);
        req = '0;
        tick(); tick(); tick(); tick();

        // ROM_LAT=3 instance: latency, then reset in the middle of a burst
        addr3[0 +: AW] = 5'h07;
        for (int k = 1; k < N; k++) addr3[k*AW +: AW] = 5'(k + 20);
        req3 = 4'b0001;
        tick();
        expect_grant3(0);
        req3 = '0;
        for (int i = 0; i < 6; i++) tick();
        req3 = 4'b1111;
        tick();
        chk("b3_gnt1", 32'(gnt3), 32'b0010);
        tick();
        chk("b3_gnt2", 32'(gnt3), 32'b0100);
        tick();
        chk("b3_gnt3", 32'(gnt3), 32'b1000);
        rst3_n = 1'b0;
        req3 = '0;
        tick();
        chk("r3_gnt", 32'(gnt3), 0);
        chk("r3_rom_rd", 32'(rom_rd3), 0);
        chk("r3_rom_addr", 32'(rom_addr3), 0);
        chk("r3_rsp_valid", 32'(rsp_valid3), 0);
        chk("r3_rsp_data", 32'(rsp_data3), 0);
        chk("r3_busy", 32'(busy3), 0);
        rst3_n = 1'b1;
        for (int i = 0; i < 8; i++) tick();

        chk("q1_drained", q1.size(), 0);
        chk("q3_drained", q3.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

`default_nettype wire
